// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, derived burst geometry and adapter state encoding
package cache_pkg;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int BEATS = LINE_W / BEAT_W;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFF_W) - 1);
  typedef enum logic [1:0] {IDLE, RBURST, WBURST, DONE} adapter_state_t;
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return a & LINE_MASK;
  endfunction
endpackage

// File: rtl/cacheline_adapter_if.sv
// cacheline_adapter_if: cache-side line request and memory-side burst signals
interface cacheline_adapter_if;
  import cache_pkg::*;
  logic [ADDR_W-1:0] addr_i;
  logic read_i;
  logic write_i;
  logic [LINE_W-1:0] line_i;
  logic [LINE_W-1:0] line_o;
  logic resp_o;
  logic [ADDR_W-1:0] addr_o;
  logic read_o;
  logic write_o;
  logic [BEAT_W-1:0] burst_o;
  logic [BEAT_W-1:0] burst_i;
  logic resp_i;
  modport slave (
    input addr_i, read_i, write_i, line_i, burst_i, resp_i,
    output line_o, resp_o, addr_o, read_o, write_o, burst_o
  );
  modport master (
    output addr_i, read_i, write_i, line_i, burst_i, resp_i,
    input line_o, resp_o, addr_o, read_o, write_o, burst_o
  );
endinterface

// File: rtl/cacheline_adapter.sv
// cacheline_adapter: turns one cache line request into a fixed-length memory burst
module cacheline_adapter
  import cache_pkg::*;
(
  input logic clk,
  input logic rst,
  cacheline_adapter_if.slave bus
);
  adapter_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [LINE_W-1:0] wline_q;
  logic last;
  logic busy;
  assign last = bus.resp_i && cnt_q == LAST_BEAT;
  assign busy = state_q == RBURST || state_q == WBURST;
  // state register
  always_ff @(posedge clk)
    state_q <= rst ? IDLE : state_d;
  // next state: write wins over read; DONE always returns to IDLE
  always_comb
    state_d = state_q == IDLE ? (bus.write_i ? WBURST : bus.read_i ? RBURST : IDLE)
            : state_q == DONE ? IDLE
            : last ? DONE : state_q;
  // outputs decoded from state; write beat sliced from the latched line by the counter
  always_comb begin
    bus.read_o = state_q == RBURST;
    bus.write_o = state_q == WBURST;
    bus.resp_o = state_q == DONE;
    bus.burst_o = state_q == WBURST ? wline_q[cnt_q*BEAT_W +: BEAT_W] : '0;
  end
  // request capture, beat counter and fill-line assembly
  always_ff @(posedge clk)
    if (rst) begin
      cnt_q <= '0;
      wline_q <= '0;
      bus.addr_o <= '0;
      bus.line_o <= '0;
    end else begin
      if (state_q == IDLE && (bus.read_i || bus.write_i)) begin
        bus.addr_o <= line_align(bus.addr_i);
        cnt_q <= '0;
        if (bus.write_i) wline_q <= bus.line_i;
      end
      if (busy && bus.resp_i) cnt_q <= last ? '0 : cnt_q + 1'b1;
      if (state_q == RBURST && bus.resp_i) bus.line_o[cnt_q*BEAT_W +: BEAT_W] <= bus.burst_i;
    end
endmodule

// File: tb/tb_cacheline_adapter.sv
// tb_cacheline_adapter: directed checks of fills, writebacks, priority, reset abort and idle noise
module tb_cacheline_adapter;
  import cache_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [LINE_W-1:0] exp_line;
  logic [BEAT_W-1:0] wb [4];
  logic pat [7];
  int b;
  cacheline_adapter_if bus();
  cacheline_adapter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [BEAT_W-1:0] rep(input logic [3:0] n);
    return {16{n}};
  endfunction
  initial begin
    bus.addr_i = '0;
    bus.read_i = 0;
    bus.write_i = 0;
    bus.line_i = '0;
    bus.burst_i = '0;
    bus.resp_i = 0;
    step();
    step();
    chk("rst_read_o", bus.read_o, 0);
    chk("rst_write_o", bus.write_o, 0);
    chk("rst_resp_o", bus.resp_o, 0);
    chk("rst_addr_o", bus.addr_o, 0);
    chk("rst_line_o", bus.line_o, 0);
    chk("rst_burst_o", bus.burst_o, 0);
    rst = 0;
    // fill without stalls
    bus.read_i = 1;
    bus.addr_i = 32'h0000_1234;
    step();
    chk("f1_addr_o", bus.addr_o, 32'h0000_1220);
    chk("f1_write_o", bus.write_o, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("f1_read_o%0d", i), bus.read_o, 1);
      chk($sformatf("f1_resp_o%0d", i), bus.resp_o, 0);
      bus.resp_i = 1;
      bus.burst_i = rep(4'(i + 1));
      step();
    end
    bus.resp_i = 0;
    bus.read_i = 0;
    exp_line = {rep(4'h4), rep(4'h3), rep(4'h2), rep(4'h1)};
    chk("f1_done_resp", bus.resp_o, 1);
    chk("f1_done_read", bus.read_o, 0);
    chk("f1_line", bus.line_o, exp_line);
    step();
    chk("f1_idle_resp", bus.resp_o, 0);
    chk("f1_line_hold", bus.line_o, exp_line);
    // fill with stalls: 1,0,0,1,0,1,1
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bus.read_i = 1;
    bus.addr_i = 32'h0000_205F;
    step();
    chk("f2_addr_o", bus.addr_o, 32'h0000_2040);
    b = 0;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("f2_read_o%0d", i), bus.read_o, 1);
      chk($sformatf("f2_resp_o%0d", i), bus.resp_o, 0);
      bus.resp_i = pat[i];
      bus.burst_i = pat[i] ? rep(4'(b + 5)) : rep(4'hF);
      if (pat[i]) b++;
      step();
    end
    bus.resp_i = 0;
    bus.read_i = 0;
    exp_line = {rep(4'h8), rep(4'h7), rep(4'h6), rep(4'h5)};
    chk("f2_done_resp", bus.resp_o, 1);
    chk("f2_done_read", bus.read_o, 0);
    chk("f2_line", bus.line_o, exp_line);
    step();
    chk("f2_idle_resp", bus.resp_o, 0);
    // writeback
    wb = '{rep(4'hA), rep(4'hB), rep(4'hC), rep(4'hD)};
    bus.write_i = 1;
    bus.addr_i = 32'h3000_00FF;
    bus.line_i = {wb[3], wb[2], wb[1], wb[0]};
    step();
    chk("wb_addr_o", bus.addr_o, 32'h3000_00E0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wb_write_o%0d", i), bus.write_o, 1);
      chk($sformatf("wb_read_o%0d", i), bus.read_o, 0);
      chk($sformatf("wb_burst_o%0d", i), bus.burst_o, wb[i]);
      bus.resp_i = 1;
      step();
    end
    bus.resp_i = 0;
    bus.write_i = 0;
    chk("wb_done_resp", bus.resp_o, 1);
    chk("wb_done_write", bus.write_o, 0);
    chk("wb_line_kept", bus.line_o, exp_line);
    step();
    chk("wb_idle_resp", bus.resp_o, 0);
    // simultaneous read+write: write first, then the held read follows
    wb = '{rep(4'h1), rep(4'h3), rep(4'h5), rep(4'h7)};
    bus.read_i = 1;
    bus.write_i = 1;
    bus.addr_i = 32'h0000_5555;
    bus.line_i = {wb[3], wb[2], wb[1], wb[0]};
    step();
    chk("pr_write_o", bus.write_o, 1);
    chk("pr_read_o", bus.read_o, 0);
    chk("pr_addr_o", bus.addr_o, 32'h0000_5540);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pr_burst_o%0d", i), bus.burst_o, wb[i]);
      bus.resp_i = 1;
      step();
    end
    bus.resp_i = 0;
    bus.write_i = 0;
    chk("pr_done_resp", bus.resp_o, 1);
    step();
    chk("pr_idle_read", bus.read_o, 0);
    chk("pr_idle_resp", bus.resp_o, 0);
    step();
    chk("pr_rd_read_o", bus.read_o, 1);
    chk("pr_rd_write_o", bus.write_o, 0);
    chk("pr_rd_addr_o", bus.addr_o, 32'h0000_5540);
    for (int i = 0; i < 4; i++) begin
      bus.resp_i = 1;
      bus.burst_i = rep(4'(i + 9));
      step();
    end
    bus.resp_i = 0;
    bus.read_i = 0;
    exp_line = {rep(4'hC), rep(4'hB), rep(4'hA), rep(4'h9)};
    chk("pr_rd_resp", bus.resp_o, 1);
    chk("pr_rd_line", bus.line_o, exp_line);
    step();
    // reset in the middle of a fill
    bus.read_i = 1;
    bus.addr_i = 32'h0000_0104;
    step();
    bus.resp_i = 1;
    bus.burst_i = rep(4'h7);
    step();
    bus.burst_i = rep(4'h8);
    step();
    rst = 1;
    bus.read_i = 0;
    bus.burst_i = rep(4'h9);
    step();
    chk("ra_read_o", bus.read_o, 0);
    chk("ra_resp_o", bus.resp_o, 0);
    chk("ra_line_o", bus.line_o, 0);
    chk("ra_addr_o", bus.addr_o, 0);
    rst = 0;
    bus.resp_i = 0;
    step();
    chk("ra_idle_resp", bus.resp_o, 0);
    bus.read_i = 1;
    step();
    chk("ra_f_read_o", bus.read_o, 1);
    chk("ra_f_addr_o", bus.addr_o, 32'h0000_0100);
    for (int i = 0; i < 4; i++) begin
      bus.resp_i = 1;
      bus.burst_i = rep(4'(i + 12));
      step();
    end
    bus.resp_i = 0;
    bus.read_i = 0;
    exp_line = {rep(4'hF), rep(4'hE), rep(4'hD), rep(4'hC)};
    chk("ra_f_resp", bus.resp_o, 1);
    chk("ra_f_line", bus.line_o, exp_line);
    step();
    // spurious memory responses while idle
    bus.resp_i = 1;
    bus.burst_i = rep(4'h6);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("sp_read_o%0d", i), bus.read_o, 0);
      chk($sformatf("sp_write_o%0d", i), bus.write_o, 0);
      chk($sformatf("sp_resp_o%0d", i), bus.resp_o, 0);
      chk($sformatf("sp_line_o%0d", i), bus.line_o, exp_line);
    end
    bus.resp_i = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
